// File: rtl/expr_pipe_alu_if.sv
// Request/result bundle for expr_pipe_alu: operands and control in, elastic result out.
interface expr_pipe_alu_if #(
  parameter int unsigned WIDTH = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             a_signed;
  logic             b_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             flag;
  logic             busy;

  modport master (
    output in_valid, op, a_signed, b_signed, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, y, flag, busy
  );

  modport slave (
    input  in_valid, op, a_signed, b_signed, a, b, acc_clr, out_ready,
    output in_ready, out_valid, y, flag, busy
  );
endinterface

// File: rtl/expr_pipe_alu.sv
// Eight-op mixed-signedness ALU with optional accumulator, followed by a
// STAGES-deep elastic valid/ready result pipeline.
module expr_pipe_alu #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned STAGES = 2,
  parameter int unsigned ACC_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  expr_pipe_alu_if.slave  bus
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned PW = 2 * WIDTH;

  typedef struct packed {
    logic         flag;
    logic [W-1:0] y;
  } res_t;

  logic          sc;
  logic          lt;
  logic [W:0]    add_s;
  logic [W:0]    sub_d;
  logic [W:0]    acc_s;
  logic [PW-1:0] ea;
  logic [PW-1:0] eb;
  logic [PW-1:0] prod;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  acc_base;
  logic          accept;
  res_t          res_c;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  res_t              st [STAGES];

  // Result of the presented transaction; signed only when both operands are signed
  always_comb begin
    sc       = bus.a_signed && bus.b_signed;
    add_s    = {1'b0, bus.a} + {1'b0, bus.b};
    sub_d    = {1'b0, bus.a} - {1'b0, bus.b};
    ea       = sc ? {{W{bus.a[W-1]}}, bus.a} : {{W{1'b0}}, bus.a};
    eb       = sc ? {{W{bus.b[W-1]}}, bus.b} : {{W{1'b0}}, bus.b};
    prod     = ea * eb;
    lt       = sc ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);
    acc_base = bus.acc_clr ? '0 : acc_q;
    acc_s    = {1'b0, acc_base} + {1'b0, bus.a};
    res_c    = '0;
    case (bus.op)
      3'd0: begin
        res_c.y    = add_s[W-1:0];
        res_c.flag = sc ? ((bus.a[W-1] == bus.b[W-1]) && (add_s[W-1] != bus.a[W-1]))
                        : add_s[W];
      end
      3'd1: begin
        res_c.y    = sub_d[W-1:0];
        res_c.flag = sc ? ((bus.a[W-1] != bus.b[W-1]) && (sub_d[W-1] != bus.a[W-1]))
                        : sub_d[W];
      end
      3'd2: begin
        res_c.y    = prod[W-1:0];
        res_c.flag = sc ? (prod[PW-1:W] != {W{prod[W-1]}}) : (|prod[PW-1:W]);
      end
      3'd3: res_c.y = (32'(bus.b) >= W) ? '0 : (bus.a << bus.b);
      3'd4: begin
        if (32'(bus.b) >= W)
          res_c.y = bus.a_signed ? {W{bus.a[W-1]}} : '0;
        else if (bus.a_signed)
          res_c.y = W'($signed(bus.a) >>> bus.b);
        else
          res_c.y = bus.a >> bus.b;
      end
      3'd5: res_c.y = W'(lt);
      3'd6: res_c.y = W'(^{bus.a, bus.b});
      default: begin
        if (ACC_EN != 0) begin
          res_c.y    = acc_s[W-1:0];
          res_c.flag = bus.a_signed
                     ? ((acc_base[W-1] == bus.a[W-1]) && (acc_s[W-1] != bus.a[W-1]))
                     : acc_s[W];
        end
      end
    endcase
  end

  // A stage can take new data unless it and every stage after it are full and stalled
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    assign adv[k] = !(&v[STAGES-1:k]) || bus.out_ready;
  end

  assign bus.in_ready = !reset && adv[0];
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) st[k] <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= accept;
        if (accept) st[0] <= res_c;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) st[k] <= st[k-1];
        end
      end
    end
  end

  if (ACC_EN != 0) begin : g_acc
    // An acc_clr without an accepted op 7 still zeroes the accumulator
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        acc_q <= '0;
      else if (accept && (bus.op == 3'd7))
        acc_q <= acc_s[W-1:0];
      else if (bus.acc_clr)
        acc_q <= '0;
    end
  end else begin : g_no_acc
    assign acc_q = '0;
  end

  assign bus.out_valid = v[STAGES-1];
  assign bus.y         = st[STAGES-1].y;
  assign bus.flag      = st[STAGES-1].flag;
  assign bus.busy      = |v;

endmodule

// File: tb/tb_expr_pipe_alu.sv
// Directed + randomized scoreboard bench for expr_pipe_alu (WIDTH=6, STAGES=2).
module tb_expr_pipe_alu;

  logic clk = 1'b0;
  logic rst;

  expr_pipe_alu_if #(.WIDTH(6)) bus ();

  expr_pipe_alu #(.WIDTH(6), .STAGES(2), .ACC_EN(1)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  logic       last_ov, last_ir, last_acc;
  logic       hold_v, hold_f;
  logic [5:0] hold_y;
  logic       use_given, given_f;
  logic [5:0] given_y;
  logic [5:0] acc_m;
  logic [6:0] q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the operand values, result taken mod 64
  function automatic logic [6:0] model(input logic [2:0] op, input logic as_, input logic bs_,
                                       input logic [5:0] a_, input logic [5:0] b_,
                                       input logic clr, input logic [5:0] acc);
    int ua, ub, sa, sb, va, vb, r, base, sbase;
    logic sc, f;
    ua = int'(a_);
    ub = int'(b_);
    sa = a_[5] ? ua - 64 : ua;
    sb = b_[5] ? ub - 64 : ub;
    sc = as_ && bs_;
    va = sc ? sa : ua;
    vb = sc ? sb : ub;
    f  = 1'b0;
    r  = 0;
    case (op)
      3'd0: begin r = va + vb; f = sc ? (r > 31 || r < -32) : (r > 63); end
      3'd1: begin r = va - vb; f = sc ? (r > 31 || r < -32) : (r < 0); end
      3'd2: begin r = va * vb; f = sc ? (r > 31 || r < -32) : (r > 63); end
      3'd3: r = (ub >= 6) ? 0 : (ua << ub);
      3'd4: begin
        if (as_) r = (ub >= 6) ? ((sa < 0) ? 63 : 0) : (sa >>> ub);
        else     r = (ub >= 6) ? 0 : (ua >> ub);
      end
      3'd5: r = (va < vb) ? 1 : 0;
      3'd6: r = $countones({a_, b_}) & 1;
      default: begin
        base = clr ? 0 : int'(acc);
        if (as_) begin
          sbase = (base > 31) ? base - 64 : base;
          r = sbase + sa;
          f = (r > 31 || r < -32);
        end else begin
          r = base + ua;
          f = (r > 63);
        end
      end
    endcase
    return {f, r[5:0]};
  endfunction

  // One clock: sample at negedge, score outputs/accepts, return 1 time unit after posedge
  task automatic cycle();
    logic [6:0] e;
    @(negedge clk);
    last_ov  = bus.out_valid;
    last_ir  = bus.in_ready;
    last_acc = 1'b0;
    if (hold_v) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_y", bus.y, hold_y);
      chk("stall_flag", bus.flag, hold_f);
    end
    hold_v = 1'b0;
    if (bus.out_valid) begin
      if (bus.out_ready) begin
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("y", bus.y, e[5:0]);
          chk("flag", bus.flag, e[6]);
        end
      end else begin
        hold_v = 1'b1;
        hold_y = bus.y;
        hold_f = bus.flag;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      last_acc = 1'b1;
      e = model(bus.op, bus.a_signed, bus.b_signed, bus.a, bus.b, bus.acc_clr, acc_m);
      q.push_back(use_given ? {given_f, given_y} : e);
      if (bus.op == 3'd7) acc_m = e[5:0];
      else if (bus.acc_clr) acc_m = '0;
    end else if (bus.acc_clr) begin
      acc_m = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic as_, input logic bs_,
                      input logic [5:0] a_, input logic [5:0] b_, input logic clr,
                      input logic ug, input logic [5:0] gy, input logic gf);
    bus.op = op; bus.a_signed = as_; bus.b_signed = bs_;
    bus.a = a_; bus.b = b_; bus.acc_clr = clr;
    use_given = ug; given_y = gy; given_f = gf;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_acc) break;
    end
    chk("accept", last_acc, 1);
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    use_given    = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen_drop;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.a_signed = 1'b0; bus.b_signed = 1'b0;
    bus.a = '0; bus.b = '0; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;
    hold_v = 1'b0; hold_f = 1'b0; hold_y = '0; use_given = 1'b0;
    given_y = '0; given_f = 1'b0; acc_m = '0;
    last_ov = 1'b0; last_ir = 1'b0; last_acc = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_flag", bus.flag, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD overflow with latency check
    send(3'd0, 1, 1, 6'd31, 6'd1, 0, 1, 6'b100000, 1);
    cycle(); chk("add_s_lat_early", last_ov, 0);
    cycle(); chk("add_s_lat_due", last_ov, 1);
    send(3'd0, 0, 0, 6'd63, 6'd1, 0, 1, 6'd0, 1);
    cycle(); chk("add_u_lat_early", last_ov, 0);
    cycle(); chk("add_u_lat_due", last_ov, 1);

    // LT, SHR, MUL
    send(3'd5, 1, 0, 6'b111111, 6'd1, 0, 1, 6'd0, 0);
    send(3'd5, 1, 1, 6'b111111, 6'd1, 0, 1, 6'd1, 0);
    send(3'd4, 1, 0, 6'b100100, 6'd2, 0, 1, 6'b111001, 0);
    send(3'd4, 0, 0, 6'b100100, 6'd2, 0, 1, 6'b001001, 0);
    send(3'd4, 1, 0, 6'b100100, 6'd9, 0, 1, 6'b111111, 0);
    send(3'd2, 1, 1, 6'b111101, 6'd5, 0, 1, 6'b110001, 0);
    send(3'd2, 0, 0, 6'd9, 6'd9, 0, 1, 6'd17, 1);
    drain();

    // Backpressure: 5 back-to-back ops, out_ready low for 3 cycles
    bus.out_ready = 1'b0;
    n = 0;
    seen_drop = 1'b0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (c == 3) bus.out_ready = 1'b1;
      bus.op = 3'(n); bus.a_signed = 1'b0; bus.b_signed = 1'b0;
      bus.a = 6'(n * 7 + 1); bus.b = 6'(n + 1); bus.in_valid = 1'b1;
      cycle();
      if (!last_ir && !seen_drop) begin
        seen_drop = 1'b1;
        chk("in_ready_drop_after", n, 2);
      end
      if (c == 3) chk("full_pushpop_ready", last_ir, 1);
      if (last_acc) n++;
    end
    chk("bp_drop_seen", seen_drop, 1);
    chk("bp_all_accepted", n, 5);
    drain();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 150; c++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      bus.op        = 3'($urandom_range(7));
      bus.a_signed  = 1'($urandom_range(1));
      bus.b_signed  = 1'($urandom_range(1));
      bus.a         = 6'($urandom_range(63));
      bus.b         = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : 6'($urandom_range(7));
      bus.acc_clr   = ($urandom_range(7) == 0);
      cycle();
    end
    bus.acc_clr = 1'b0;
    drain();

    // Accumulator chain
    send(3'd7, 0, 0, 6'd5, 6'd0, 1, 1, 6'd5, 0);
    send(3'd7, 1, 0, 6'b111110, 6'd0, 0, 1, 6'd3, 0);
    send(3'd7, 0, 0, 6'd3, 6'd0, 0, 1, 6'd6, 0);
    drain();

    // Reset with two results in flight
    bus.out_ready = 1'b0;
    send(3'd0, 0, 0, 6'd10, 6'd4, 0, 0, 6'd0, 0);
    send(3'd1, 0, 0, 6'd10, 6'd4, 0, 0, 6'd0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    q.delete();
    acc_m  = '0;
    hold_v = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(3'd7, 0, 0, 6'd1, 6'd0, 0, 1, 6'd1, 0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/expr_pipe_alu.md
# expr_pipe_alu

Parametrised, pipelined successor to the team's flat mixed-signedness expression blocks. It evaluates one of eight Verilog-semantics operations on two WIDTH-bit operands, each with a per-transaction signedness flag. Results pass through a STAGES-deep elastic valid/ready pipeline, and an optional running accumulator is available. It sits between the expression stimulus generator and the result scoreboard in the regression harness.

## Interface
- WIDTH, 6, operand/result width (2..32)
- STAGES, 2, pipeline register stages (1..4); also the in-flight capacity
- ACC_EN, 1, 1 = accumulator present; 0 = op 7 returns 0
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  transaction present
- in_ready  output  1  block accepts the transaction this cycle
- op  input  3  operation select
- a_signed  input  1  a is signed
- b_signed  input  1  b is signed
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- acc_clr  input  1  clear accumulator
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  result
- flag  output  1  overflow/carry indication for the result
- busy  output  1  any stage valid

## Operation
- Accept = in_valid && in_ready. The result is computed combinationally from the inputs and captured into stage 0 on accept. Later stages only delay the result.
- Signed context: an operation is signed only when a_signed && b_signed. Otherwise both operands are treated as unsigned (Verilog rule).
- op 0 ADD and op 1 SUB: y = low WIDTH bits.
  - Signed context: flag = signed overflow.
  - Unsigned context: flag = carry-out (ADD) or borrow (SUB).
- op 2 MUL: y = low WIDTH bits of the 2*WIDTH product.
  - Signed context: flag = 1 if the high half is not the sign-extension of y.
  - Unsigned context: flag = 1 if the high half is nonzero.
- op 3 SHL: shift amount = b, always unsigned. If b >= WIDTH, y = 0. flag = 0.
- op 4 SHR: arithmetic if a_signed, logical otherwise; b_signed is ignored. If b >= WIDTH, y = all sign bits (arithmetic) or 0 (logical). flag = 0.
- op 5 LT: y = zero-extended (a < b) in the signed context rule above. flag = 0.
- op 6 REDXOR: y = zero-extended ^{a,b}. flag = 0.
- op 7 ACC (ACC_EN=1):
  - acc_next = acc + ext(a), where ext sign-extends if a_signed and zero-extends otherwise.
  - y = acc_next.
  - flag = overflow per a_signed: signed overflow if a_signed, carry-out otherwise.
  - acc updates on accept.
- acc_clr:
  - With an accepted op 7: acc is treated as 0 before the add, so y = ext(a).
  - With any other accept, or with no accept: acc <= 0 that cycle.
- ACC_EN=0: op 7 gives y = 0, flag = 0, and acc is absent.
- Pipeline flow:
  - Stage k advances when stage k is empty or stage k+1 advances.
  - The last stage advances when out_ready is high.
  - in_ready = !reset && (stage 0 empty || stage 0 advances).
  - in_ready is combinational and never depends on in_valid.
- Ordering is strictly FIFO. No transaction is dropped or duplicated.
- y and flag hold stable while out_valid && !out_ready.

## Timing
- Reset: all stage valids = 0, y = 0, flag = 0, acc = 0, busy = 0, out_valid = 0, in_ready = 0 while reset is high.
- Reset asserted mid-stream: all in-flight results are discarded immediately (asynchronous) and acc clears.
- Latency: with no backpressure, a transaction accepted at edge N appears with out_valid = 1 after edge N+STAGES-1. That is STAGES cycles from in_valid to out_valid.
- Throughput is 1 per cycle with out_ready held high.
- Full condition: STAGES results held and out_ready = 0. in_ready drops in that same cycle.
- Simultaneous pop and push when full: both occur, and in_ready stays 1.
- The acc update is visible to the next accepted op 7 in the following cycle, so back-to-back ACC ops chain correctly.

## Test plan
All scenarios use WIDTH=6, STAGES=2.
- ADD overflow:
  - Signed: a=31, b=1 -> y=6'b100000, flag=1.
  - Unsigned: a=63, b=1 -> y=0, flag=1.
  - Each result appears 2 cycles after accept.
- LT mixed signedness: a=6'b111111, b=1.
  - a_signed=1, b_signed=0 -> y=0.
  - Both signed -> y=1.
- SHR:
  - a=6'b100100, b=2, a_signed=1 -> 6'b111001.
  - Same with a_signed=0 -> 6'b001001.
  - b=9, a_signed=1 -> 6'b111111.
- MUL:
  - Signed -3*5 -> y=6'b110001, flag=0.
  - Unsigned 9*9 -> y=17, flag=1.
- Backpressure: push 5 ops back-to-back, out_ready=0 for 3 cycles.
  - in_ready falls after 2 accepts.
  - All 5 results emerge in order, with y stable while stalled.
- ACC and reset:
  - Sequence: op 7 with acc_clr and a=5; then a=-2 signed; then a=3 unsigned -> y = 5, 3, 6.
  - Assert reset with 2 results in flight -> out_valid=0 at once.
  - After reset, op 7 with a=1 -> y=1.
